// File: rtl/fpu_pkg.sv
// Shared FPU field widths, the reciprocal-unit state encoding and
// IEEE-754 single-precision field extractors used by finv/fdiv/fmul.
package fpu_pkg;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int QBITS    = 25;
  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = FRAC_W + 1;
  // Remainder peaks just under 2*M before the compare, plus one spare bit.
  localparam int REM_W    = MANT_W + 2;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    ROUND,
    DONE
  } finv_state_t;

  function automatic logic f_sign(input logic [31:0] v);
    return v[31];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] v);
    return v[30:23];
  endfunction

  function automatic logic [FRAC_W-1:0] f_frac(input logic [31:0] v);
    return v[22:0];
  endfunction
endpackage

// File: rtl/finv_round.sv
// Turns the 25-bit reciprocal quotient into the final IEEE word:
// RNE rounding, carry renormalisation, special exponents and flush-to-zero.
module finv_round
  import fpu_pkg::*;
(
  input  logic              s,
  input  logic [EXP_W-1:0]  e,
  input  logic [FRAC_W-1:0] f,
  input  logic [QBITS-1:0]  q,
  input  logic              sticky,
  output logic [31:0]       y
);
  logic              round_up;
  logic [MANT_W:0]   mant_rnd;
  logic [FRAC_W-1:0] frac_out;
  logic [EXP_W:0]    exp_rnd;
  logic [EXP_W-1:0]  exp_pow2;

  always_comb begin
    round_up = q[0] && (sticky || q[1]);
    mant_rnd = {1'b0, q[QBITS-1:1]} + {{MANT_W{1'b0}}, round_up};
    // A rounding carry leaves 1.000..0 one binade up.
    frac_out = mant_rnd[MANT_W] ? mant_rnd[MANT_W-1:1] : mant_rnd[FRAC_W-1:0];
    // 253 - e (+1 on carry); bit EXP_W set means the result went negative.
    exp_rnd  = (EXP_W+1)'(2*EXP_BIAS - 1) - {1'b0, e}
             + {{EXP_W{1'b0}}, mant_rnd[MANT_W]};
    exp_pow2 = EXP_W'(2*EXP_BIAS) - e;

    if (e == '0)
      y = {s, EXP_MAX, {FRAC_W{1'b0}}};
    else if (e == EXP_MAX)
      y = {s, 31'b0};
    else if (f == '0)
      y = {s, exp_pow2, {FRAC_W{1'b0}}};
    else if (exp_rnd[EXP_W] || exp_rnd == '0)
      y = {s, 31'b0};
    else
      y = {s, exp_rnd[EXP_W-1:0], frac_out};
  end
endmodule

// File: rtl/finv_seq.sv
// Sequential single-precision reciprocal y = 1/x: 25-step restoring division
// of 2^48 by the mantissa, then one rounding cycle, behind valid/ready.
module finv_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);
  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid and data hold stable until that edge, ready never depends on valid.
  localparam logic [4:0] LAST_STEP = 5'(QBITS - 1);

  finv_state_t       state;
  logic [4:0]        count;
  logic [REM_W-1:0]  rem;
  logic [QBITS-1:0]  q;
  logic              s;
  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] f;
  logic [REM_W-1:0]  m_ext;
  logic              rem_ge;
  logic [31:0]       y_rnd;

  assign in_ready = (state == IDLE);
  assign m_ext    = {{(REM_W-MANT_W){1'b0}}, 1'b1, f};
  assign rem_ge   = (rem >= m_ext);

  finv_round u_round (
    .s      (s),
    .e      (e),
    .f      (f),
    .q      (q),
    .sticky (rem != '0),
    .y      (y_rnd)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s     <= f_sign(x);
            e     <= f_exp(x);
            f     <= f_frac(x);
            rem   <= REM_W'(1 << MANT_W);
            q     <= '0;
            count <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          q   <= {q[QBITS-2:0], rem_ge};
          rem <= (rem_ge ? rem - m_ext : rem) << 1;
          if (count == LAST_STEP) state <= ROUND;
          else count <= count + 5'd1;
        end
        ROUND: begin
          y         <= y_rnd;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_finv_seq.sv
// Bench for finv_seq: directed vector table, backpressure and reset corners,
// and a back-to-back random sweep against a floating-point reference model.
module tb_finv_seq;
  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;
  vec_t vecs[9];

  finv_seq dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: real-valued 1/x (double), then RNE to 24 bits, flush below normal.
  function automatic logic [31:0] ref_finv(input logic [31:0] v);
    logic        sg;
    int          ev;
    logic [63:0] db;
    logic [63:0] rb;
    real         r;
    int          ex;
    logic [24:0] mant;
    logic        g;
    logic        st;
    sg = v[31];
    ev = int'(v[30:23]);
    if (ev == 0) return {sg, 8'hFF, 23'b0};
    if (ev == 255) return {sg, 31'b0};
    db   = {sg, 11'(ev - 127 + 1023), v[22:0], 29'b0};
    r    = 1.0 / $bitstoreal(db);
    rb   = $realtobits(r);
    ex   = int'(rb[62:52]) - 1023 + 127;
    mant = {2'b01, rb[51:29]};
    g    = rb[28];
    st   = |rb[27:0];
    if (g && (st || mant[0])) mant = mant + 25'd1;
    if (mant[24]) begin
      ex   = ex + 1;
      mant = mant >> 1;
    end
    if (ex <= 0) return {sg, 31'b0};
    return {sg, ex[7:0], mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_normal();
    logic [31:0] v;
    v[31]    = 1'($urandom_range(0, 1));
    v[30:23] = 8'($urandom_range(1, 254));
    v[22:0]  = 23'($urandom);
    return v;
  endfunction

  // driver tasks (all entered/left at #1 after a rising edge)
  task automatic do_reset();
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic accept_op(input logic [31:0] v);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    x        = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [31:0] exp);
    int lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({"latency_", name}, 32'(lat), 32'd26);
    chk({"y_", name}, y, exp);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", {31'b0, out_valid}, 32'd0);
    chk("in_ready_after_hs", {31'b0, in_ready}, 32'd1);
  endtask

  localparam int N_SWEEP = 40;

  initial begin
    int sent;
    int got;
    int last_acc;
    int last_hs;
    logic acc;

    vecs[0] = '{32'h40000000, 32'h3F000000};
    vecs[1] = '{32'h40400000, 32'h3EAAAAAB};
    vecs[2] = '{32'h3F800001, 32'h3F7FFFFE};
    vecs[3] = '{32'h3FFFFFFF, 32'h3F000001};
    vecs[4] = '{32'h80000000, 32'hFF800000};
    vecs[5] = '{32'h00400000, 32'h7F800000};
    vecs[6] = '{32'h7F800000, 32'h00000000};
    vecs[7] = '{32'h7F000000, 32'h00000000};
    vecs[8] = '{32'hFE800000, 32'h80800000};

    do_reset();
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_y", y, 32'h0);

    for (int i = 0; i < 9; i++) begin
      accept_op(vecs[i].x);
      wait_result($sformatf("vec%0d", i), vecs[i].y);
      release_out();
    end

    // Backpressure: result held while a new operand waits.
    accept_op(32'h40000000);
    wait_result("bp_first", 32'h3F000000);
    in_valid = 1'b1;
    x        = 32'h40400000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_y_hold", y, 32'h3F000000);
      chk("bp_valid_hold", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_in_ready_next", {31'b0, in_ready}, 32'd1);
    chk("bp_valid_drop", {31'b0, out_valid}, 32'd0);
    accept_op(32'h40400000);
    wait_result("bp_pending", 32'h3EAAAAAB);
    release_out();

    // Reset in the middle of the division.
    accept_op(32'h40400000);
    repeat (10) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_y", y, 32'h0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    accept_op(32'h40800000);
    wait_result("after_rst", 32'h3E800000);
    release_out();

    // Random back-to-back sweep, out_ready tied high.
    out_ready = 1'b1;
    x         = rand_normal();
    in_valid  = 1'b1;
    sent      = 0;
    got       = 0;
    last_acc  = -1;
    last_hs   = -1;
    for (int k = 0; k < N_SWEEP * 30 + 100 && got < N_SWEEP; k++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("sweep_unexpected_out", y, 32'hxxxxxxxx);
        else chk($sformatf("sweep_y%0d", got), y, exp_q.pop_front());
        chk("sweep_latency", 32'(k - last_acc), 32'd27);
        last_hs = k;
        got++;
      end
      if (acc) begin
        if (last_hs >= 0) chk("sweep_accept_after_hs", 32'(k), 32'(last_hs + 1));
        exp_q.push_back(ref_finv(x));
        last_acc = k;
        sent++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (sent < N_SWEEP) x = rand_normal();
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    chk("sweep_count", 32'(got), 32'(N_SWEEP));
    chk("sweep_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
